// File: rtl/mac_feeder.sv
// mac_feeder -- feeds operand beats into an external pipelined MAC accumulator
// and captures the running sum once the last product has drained through.
//
// Each vector runs through four phases: clear the accumulator (CLR), stream
// beats into it (ACCUM), wait for the MAC pipeline to settle (DRAIN), then
// present the captured dot product until the consumer takes it (HOLD).
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both high. s_ready depends only on state; m_valid depends only on
// state and, once high, stays high with m_data/m_len/m_trunc stable until the
// transfer.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   s_valid/s_ready      operand beat handshake
//   s_a, s_b             8-bit unsigned operands
//   s_last               final beat of a vector
//   mac_a, mac_b         registered operands to the MAC (zero when idle)
//   mac_sclr             registered synchronous clear to the MAC
//   mac_psum             20-bit running sum returned by the MAC
//   m_valid/m_ready      result handshake
//   m_data               captured dot product (mac_psum, unmodified)
//   m_len                number of beats in the captured vector
//   m_trunc              vector was cut at MAX_LEN without s_last
//   dbg_state            current FSM state, for observation only
module mac_feeder #(
  parameter int LAT     = 2,
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_a,
  input  logic [7:0]  s_b,
  input  logic        s_last,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  output logic        mac_sclr,
  input  logic [19:0] mac_psum,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [19:0] m_data,
  output logic [7:0]  m_len,
  output logic        m_trunc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_CLR   = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_CLR   = 4'(LAT - 1);
  localparam logic [3:0] CNT_DRAIN = 4'(LAT);
  localparam logic [7:0] LEN_MAX   = 8'(MAX_LEN);

  state_t      state_q,    state_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic [7:0]  bcnt_q,     bcnt_d;
  logic        trunc_q,    trunc_d;
  logic [7:0]  mac_a_q,    mac_a_d;
  logic [7:0]  mac_b_q,    mac_b_d;
  logic        mac_sclr_q, mac_sclr_d;
  logic [19:0] m_data_q,   m_data_d;
  logic [7:0]  m_len_q,    m_len_d;
  logic        m_trunc_q,  m_trunc_d;
  logic [7:0]  bcnt_inc;

  assign bcnt_inc = bcnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    trunc_d    = trunc_q;
    // Operands default to zero so that idle edges add nothing to the sum.
    mac_a_d    = 8'd0;
    mac_b_d    = 8'd0;
    mac_sclr_d = mac_sclr_q;
    m_data_d   = m_data_q;
    m_len_d    = m_len_q;
    m_trunc_d  = m_trunc_q;

    unique case (state_q)
      ST_CLR: begin
        // mac_sclr is registered, so it already reads 1 on entry; it drops on
        // the same edge that moves to ACCUM, giving exactly LAT clear cycles.
        if (cnt_q == 4'd0) begin
          state_d    = ST_ACCUM;
          bcnt_d     = 8'd0;
          mac_sclr_d = 1'b0;
        end else begin
          cnt_d      = cnt_q - 4'd1;
          mac_sclr_d = 1'b1;
        end
      end
      ST_ACCUM: begin
        mac_sclr_d = 1'b0;
        if (s_valid) begin
          mac_a_d = s_a;
          mac_b_d = s_b;
          bcnt_d  = bcnt_inc;
          if (s_last) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_DRAIN;
            trunc_d = 1'b0;
          end else if (bcnt_inc == LEN_MAX) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_DRAIN;
            trunc_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // LAT+1 cycles: the last operand register needs LAT edges to reach
        // mac_psum, and the capture happens on the edge after that.
        if (cnt_q == 4'd0) begin
          state_d   = ST_HOLD;
          m_data_d  = mac_psum;
          m_len_d   = bcnt_q;
          m_trunc_d = trunc_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          state_d    = ST_CLR;
          cnt_d      = CNT_CLR;
          mac_sclr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLR;
      cnt_q      <= CNT_CLR;
      bcnt_q     <= 8'd0;
      trunc_q    <= 1'b0;
      mac_a_q    <= 8'd0;
      mac_b_q    <= 8'd0;
      mac_sclr_q <= 1'b1;
      m_data_q   <= 20'd0;
      m_len_q    <= 8'd0;
      m_trunc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      trunc_q    <= trunc_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      mac_sclr_q <= mac_sclr_d;
      m_data_q   <= m_data_d;
      m_len_q    <= m_len_d;
      m_trunc_q  <= m_trunc_d;
    end
  end

  assign s_ready   = (state_q == ST_ACCUM);
  assign m_valid   = (state_q == ST_HOLD);
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_sclr  = mac_sclr_q;
  assign m_data    = m_data_q;
  assign m_len     = m_len_q;
  assign m_trunc   = m_trunc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Testbench for mac_feeder with a behavioural 2-stage MAC accumulator.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_mac_feeder;

  localparam int LAT     = 2;
  localparam int MAX_LEN = 16;
  localparam int W       = 29;  // {trunc, len[7:0], data[19:0]}

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_a;
  logic [7:0]  s_b;
  logic        s_last;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic        mac_sclr;
  logic [19:0] mac_psum;
  logic        m_valid;
  logic        m_ready;
  logic [19:0] m_data;
  logic [7:0]  m_len;
  logic        m_trunc;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  mac_feeder #(.LAT(LAT), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_sclr(mac_sclr), .mac_psum(mac_psum),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_len(m_len),
    .m_trunc(m_trunc), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- external MAC model ----------------
  // Product registered on one edge, accumulated on the next: LAT = 2.
  logic [15:0] prod_q;
  logic [19:0] acc_q;
  always @(posedge clk) begin
    if (mac_sclr) begin
      prod_q <= 16'd0;
      acc_q  <= 20'd0;
    end else begin
      prod_q <= mac_a * mac_b;
      acc_q  <= acc_q + 20'(prod_q);
    end
  end
  assign mac_psum = acc_q;

  // ---------------- driver tasks ----------------
  // Presents one beat and returns at the falling edge after the edge that
  // accepted it; edges = number of rising edges spent waiting, inclusive.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                           input logic last, output int edges);
    logic acc;
    s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
    edges = 0;
    acc = 1'b0;
    while (!acc && edges < 200) begin
      acc = s_ready;
      @(negedge clk);
      edges++;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_beat timeout: s_ready never high after %0d cycles", edges);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Called right after send_beat of the final beat; counts rising edges from
  // the accepting edge (counted as 1) until m_valid is observed.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!m_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    if (!m_valid) begin
      tests++; fails++;
      $display("FAIL wait_valid timeout: m_valid low after %0d cycles", edges);
    end
  endtask

  task automatic release_result();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic apply_reset_pulse(output int sclr_cycles);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sclr_cycles = 0;
    while (mac_sclr && sclr_cycles < 50) begin
      sclr_cycles++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int sc;
    rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    tests++; if (mac_sclr !== 1'b1) begin fails++; $display("FAIL reset_mac_sclr got=%b exp=1", mac_sclr); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    tests++; if ({mac_a, mac_b} !== 16'd0) begin fails++; $display("FAIL reset_mac_ab got=%h exp=0", {mac_a, mac_b}); end
    tests++; if ({m_trunc, m_len, m_data} !== 29'd0) begin fails++; $display("FAIL reset_result got=%h exp=0", {m_trunc, m_len, m_data}); end
    rst_n = 1'b1;
    sc = 0;
    while (mac_sclr && sc < 50) begin sc++; @(negedge clk); end
    tests++; if (sc !== LAT) begin fails++; $display("FAIL reset_clr_len got=%0d exp=%0d", sc, LAT); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after_clr got=%b exp=1", s_ready); end
  endtask

  task automatic test_basic();
    int e;
    send_beat(8'd1, 8'd2, 1'b0, e);
    tests++; if ({mac_a, mac_b} !== {8'd1, 8'd2}) begin fails++; $display("FAIL basic_mac_ab got=%h exp=0102", {mac_a, mac_b}); end
    send_beat(8'd3, 8'd4, 1'b0, e);
    send_beat(8'd5, 8'd6, 1'b1, e);
    wait_valid(e);
    tests++; if (e !== LAT + 2) begin fails++; $display("FAIL basic_latency got=%0d exp=%0d", e, LAT + 2); end
    tests++; if (m_data !== 20'd44) begin fails++; $display("FAIL basic_data got=%0d exp=44", m_data); end
    tests++; if (m_len !== 8'd3) begin fails++; $display("FAIL basic_len got=%0d exp=3", m_len); end
    tests++; if (m_trunc !== 1'b0) begin fails++; $display("FAIL basic_trunc got=%b exp=0", m_trunc); end
    release_result();
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got=%b exp=0", m_valid); end
    tests++; if (m_data !== 20'd44) begin fails++; $display("FAIL basic_data_held got=%0d exp=44", m_data); end
  endtask

  task automatic test_bubbles();
    int e;
    send_beat(8'd1, 8'd2, 1'b0, e);
    repeat (3) @(negedge clk);
    tests++; if ({mac_a, mac_b} !== 16'd0) begin fails++; $display("FAIL bubble_zero_operands got=%h exp=0", {mac_a, mac_b}); end
    send_beat(8'd3, 8'd4, 1'b0, e);
    repeat (3) @(negedge clk);
    send_beat(8'd5, 8'd6, 1'b1, e);
    wait_valid(e);
    tests++; if (m_data !== 20'd44) begin fails++; $display("FAIL bubble_data got=%0d exp=44", m_data); end
    tests++; if (m_len !== 8'd3) begin fails++; $display("FAIL bubble_len got=%0d exp=3", m_len); end
    release_result();
  endtask

  task automatic test_trunc();
    int e;
    for (int i = 0; i < MAX_LEN; i++) send_beat(8'd255, 8'd255, 1'b0, e);
    // beat 17 is presented but must wait for the next vector
    s_a = 8'd255; s_b = 8'd255; s_last = 1'b0; s_valid = 1'b1;
    wait_valid(e);
    tests++; if (e !== LAT + 2) begin fails++; $display("FAIL trunc_latency got=%0d exp=%0d", e, LAT + 2); end
    tests++; if (m_data !== 20'd1040400) begin fails++; $display("FAIL trunc_data got=%0d exp=1040400", m_data); end
    tests++; if (m_len !== 8'd16) begin fails++; $display("FAIL trunc_len got=%0d exp=16", m_len); end
    tests++; if (m_trunc !== 1'b1) begin fails++; $display("FAIL trunc_flag got=%b exp=1", m_trunc); end
    release_result();
    send_beat(8'd255, 8'd255, 1'b0, e);
    tests++; if (e !== LAT + 1) begin fails++; $display("FAIL trunc_beat17_wait got=%0d exp=%0d", e, LAT + 1); end
    send_beat(8'd1, 8'd1, 1'b1, e);
    wait_valid(e);
    tests++; if ({m_trunc, m_len, m_data} !== {1'b0, 8'd2, 20'd65026}) begin
      fails++; $display("FAIL trunc_next_vector got=%b/%0d/%0d exp=0/2/65026", m_trunc, m_len, m_data);
    end
    release_result();
  endtask

  task automatic test_hold();
    int e;
    send_beat(8'd7, 8'd9, 1'b1, e);
    wait_valid(e);
    for (int i = 0; i < 5; i++) begin
      tests++; if ({m_valid, m_len, m_data} !== {1'b1, 8'd1, 20'd63}) begin
        fails++; $display("FAIL hold_stable cyc=%0d got=%b/%0d/%0d exp=1/1/63", i, m_valid, m_len, m_data);
      end
      @(negedge clk);
    end
    m_ready = 1'b1;
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL hold_last_cycle got=%b exp=1", m_valid); end
    @(negedge clk);
    m_ready = 1'b0;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL hold_release got=%b exp=0", m_valid); end
  endtask

  task automatic test_back_to_back();
    int e;
    m_ready = 1'b1;
    send_beat(8'd2, 8'd2, 1'b1, e);
    wait_valid(e);
    tests++; if (m_data !== 20'd4) begin fails++; $display("FAIL b2b_first got=%0d exp=4", m_data); end
    @(negedge clk);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL b2b_one_hold_cycle got=%b exp=0", m_valid); end
    send_beat(8'd3, 8'd3, 1'b1, e);
    wait_valid(e);
    tests++; if (m_data !== 20'd9) begin fails++; $display("FAIL b2b_second got=%0d exp=9", m_data); end
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int e, sc;
    send_beat(8'd10, 8'd10, 1'b0, e);
    send_beat(8'd11, 8'd11, 1'b0, e);
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if ({s_ready, m_valid, mac_sclr, mac_a, mac_b} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
      fails++; $display("FAIL rstmid_outputs got=%b%b%b %h exp=001 0000", s_ready, m_valid, mac_sclr, {mac_a, mac_b});
    end
    tests++; if ({m_trunc, m_len, m_data} !== 29'd0) begin fails++; $display("FAIL rstmid_result got=%h exp=0", {m_trunc, m_len, m_data}); end
    rst_n = 1'b1;
    sc = 0;
    while (mac_sclr && sc < 50) begin sc++; @(negedge clk); end
    tests++; if (sc !== LAT) begin fails++; $display("FAIL rstmid_clr_len got=%0d exp=%0d", sc, LAT); end
    send_beat(8'd1, 8'd1, 1'b1, e);
    wait_valid(e);
    tests++; if ({m_len, m_data} !== {8'd1, 20'd1}) begin fails++; $display("FAIL rstmid_next got=%0d/%0d exp=1/1", m_len, m_data); end
    // reset while a result is pending discards it
    apply_reset_pulse(sc);
    tests++; if ({m_valid, m_data} !== 21'd0) begin fails++; $display("FAIL rsthold_discard got=%b/%0d exp=0/0", m_valid, m_data); end
    tests++; if (sc !== LAT) begin fails++; $display("FAIL rsthold_clr_len got=%0d exp=%0d", sc, LAT); end
  endtask

  task automatic test_random();
    int e, len, bub, dly;
    logic [7:0] a, b;
    logic [19:0] sum;
    logic last_sent;
    logic [W-1:0] exp_v;
    for (int v = 0; v < 30; v++) begin
      len = $urandom_range(1, MAX_LEN);
      // length-16 vectors sometimes omit s_last to exercise truncation
      last_sent = !(len == MAX_LEN && $urandom_range(0, 1) == 1);
      sum = 20'd0;
      for (int i = 0; i < len; i++) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        sum = sum + 20'(a) * 20'(b);
        bub = $urandom_range(0, 2);
        repeat (bub) @(negedge clk);
        m_ready = 1'($urandom_range(0, 1));  // ignored outside HOLD
        send_beat(a, b, (i == len - 1) ? last_sent : 1'b0, e);
      end
      m_ready = 1'b0;
      exp_q.push_back({~last_sent, 8'(len), sum});
      wait_valid(e);
      tests++; if (e !== LAT + 2) begin fails++; $display("FAIL rand_latency vec=%0d got=%0d exp=%0d", v, e, LAT + 2); end
      dly = $urandom_range(0, 3);
      repeat (dly) @(negedge clk);
      exp_v = exp_q.pop_front();
      tests++; if ({m_trunc, m_len, m_data} !== exp_v) begin
        fails++; $display("FAIL rand_result vec=%0d got=%b/%0d/%0d exp=%b/%0d/%0d",
                          v, m_trunc, m_len, m_data, exp_v[28], exp_v[27:20], exp_v[19:0]);
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_trunc();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter LAT, default 2, meaning clock edges from mac_a/mac_b being driven until that product is visible on mac_psum; legal range 1..15.
REQ-002 Parameter MAX_LEN, default 16, meaning maximum beats per vector (1..16, so the unsigned 8x8 sum cannot overflow 20 bits).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 s_valid  in  1  operand beat valid.
REQ-006 s_ready  out  1  block accepts a beat this cycle.
REQ-007 s_a, s_b  in  8 each  unsigned operands.
REQ-008 s_last  in  1  beat is the final beat of a vector.
REQ-009 mac_a, mac_b  out  8 each  registered operands to the MAC accumulator.
REQ-010 mac_sclr  out  1  registered synchronous clear to the MAC accumulator.
REQ-011 mac_psum  in  20  running sum from the MAC accumulator.
REQ-012 m_valid  out  1  dot-product result valid.
REQ-013 m_ready  in  1  downstream accepts the result.
REQ-014 m_data  out  20  captured dot product.
REQ-015 m_len  out  8  beats in the captured vector.
REQ-016 m_trunc  out  1  vector was cut at MAX_LEN without s_last.

Function
REQ-017 The FSM SHALL have the states CLR, ACCUM, DRAIN and HOLD, with one down-counter cnt of 4 bits and one beat counter bcnt of 8 bits.
REQ-018 In CLR: mac_sclr=1, mac_a=mac_b=0, s_ready=0; CLR lasts exactly LAT cycles (cnt loaded with LAT-1, exit when cnt==0), then ACCUM with bcnt=0.
REQ-019 In ACCUM: s_ready=1 and mac_sclr=0; a beat is accepted on an edge where s_valid&&s_ready.
REQ-020 Accepted beat: mac_a/mac_b SHALL load s_a/s_b on that edge and bcnt SHALL increment.
REQ-021 Any edge in any state without an accepted beat SHALL load mac_a=mac_b=0 (zero product; the accumulator holds).
REQ-022 Bubbles (s_valid=0) mid-vector SHALL NOT affect the result.
REQ-023 Accepting a beat with s_last=1 SHALL move the FSM to DRAIN with cnt=LAT and trunc=0.
REQ-024 Accepting a beat with s_last=0 that makes bcnt==MAX_LEN SHALL move the FSM to DRAIN with cnt=LAT and trunc=1.
REQ-025 In DRAIN: s_ready=0; cnt decrements each cycle, so DRAIN lasts LAT+1 cycles.
REQ-026 On the DRAIN edge with cnt==0: m_data<=mac_psum, m_len<=bcnt, m_trunc<=trunc, and the FSM enters HOLD.
REQ-027 Latency: m_valid SHALL rise LAT+2 cycles after the edge accepting the last beat.
REQ-028 In HOLD: m_valid=1, s_ready=0; m_data, m_len and m_trunc SHALL be stable until the handshake completes.
REQ-029 When m_valid&&m_ready, the FSM SHALL enter CLR on the same edge; m_valid=0 next cycle; m_data, m_len and m_trunc hold their last values.
REQ-030 m_ready already high on HOLD entry SHALL give exactly one HOLD cycle.
REQ-031 m_ready outside HOLD SHALL be ignored.
REQ-032 A single-beat vector (s_last on the first beat) SHALL give m_len=1.
REQ-033 s_ready SHALL depend on state only, never on s_valid or m_ready.
REQ-034 The beat after a truncated vector SHALL NOT be consumed until the next ACCUM; it becomes beat 1 of the next vector.
REQ-035 Arithmetic SHALL be done only by the external MAC; m_data is mac_psum sampled unmodified at full 20-bit width.

Reset
REQ-036 With rst_n=0 at a rising edge: state=CLR, cnt=LAT-1, bcnt=0, mac_a=mac_b=0, mac_sclr=1, s_ready=0, m_valid=0, m_data=0, m_len=0, m_trunc=0.
REQ-037 Reset asserted in any state, including mid-vector or in HOLD, SHALL discard the partial vector and pending result, and restart through a full LAT-cycle CLR.

Verification (bench uses a behavioural MAC model with LAT=2, MAX_LEN=16)
REQ-038 Beats (1,2),(3,4),(5,6) with last on the third -> m_data=44, m_len=3, m_trunc=0; m_valid rises 4 cycles after the third accept.
REQ-039 Same vector with s_valid dropped for 3 cycles between beats -> m_data=44, m_len=3.
REQ-040 17 beats of (255,255), no s_last -> m_data=1040400, m_len=16, m_trunc=1; beat 17 is accepted only after CLR and starts a new vector.
REQ-041 Single beat (7,9,last), m_ready held low 5 cycles -> m_valid high with m_data=63, m_len=1 stable for all 5 cycles; one more cycle after m_ready rises.
REQ-042 Back-to-back vectors [(2,2)] and [(3,3)] with m_ready=1 -> results 4 then 9; the second is not contaminated by the first.
REQ-043 rst_n low for 1 cycle after 2 beats of a vector -> all outputs at reset values; mac_sclr high for 2 cycles; next vector [(1,1)] -> m_data=1.
